// File: rtl/router_pkg.sv
// ----------------------------------------------------------------------------
// router_pkg
// Shared definitions for the wormhole router switch-allocation stage.
// Contents:
//   NPORT, FLIT_W        port count (fixed at 5) and flit width
//   DIR_* / IDX_*        one-hot direction codes and their port indices
//   grant_t              registered grant record {valid, input index}
//   isOneHot5, dirCode   small helpers used by the allocator
// ----------------------------------------------------------------------------
package router_pkg;

    localparam int NPORT  = 5;
    localparam int FLIT_W = 64;

    localparam logic [4:0] DIR_N = 5'b00001;
    localparam logic [4:0] DIR_E = 5'b00010;
    localparam logic [4:0] DIR_S = 5'b00100;
    localparam logic [4:0] DIR_W = 5'b01000;
    localparam logic [4:0] DIR_L = 5'b10000;

    localparam logic [2:0] IDX_N = 3'd0;
    localparam logic [2:0] IDX_E = 3'd1;
    localparam logic [2:0] IDX_S = 3'd2;
    localparam logic [2:0] IDX_W = 3'd3;
    localparam logic [2:0] IDX_L = 3'd4;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } grant_t;

    // True when exactly one bit of a 5-bit request vector is set.
    function automatic logic isOneHot5(input logic [4:0] v);
        return (v != 5'd0) && ((v & (v - 5'd1)) == 5'd0);
    endfunction

    // Direction code of a port index (index 0 -> 5'b00001 ... 4 -> 5'b10000).
    function automatic logic [4:0] dirCode(input logic [2:0] idx);
        return 5'b00001 << idx;
    endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// ----------------------------------------------------------------------------
// switch_allocator_if
// Bundle of the allocation/traversal signals between the five input ports,
// the switch allocator and the downstream output links.
//   sa_request, outport_req, flit_in, valid_flit_in   from input ports
//   valid_downstream_ports                            from downstream links
//   sa_grant                                          to input ports
//   flit_out, valid_flit_out                          to downstream links
//   protocol_err                                      sticky status
// Modports: master = the router side around the allocator (inputs ports and
// downstream links), slave = the allocator itself.
// ----------------------------------------------------------------------------
interface switch_allocator_if #(parameter int FLIT_W = router_pkg::FLIT_W);

    logic [4:0]             sa_request;
    logic [4:0][4:0]        outport_req;
    logic [4:0][FLIT_W-1:0] flit_in;
    logic [4:0]             valid_flit_in;
    logic [4:0]             valid_downstream_ports;
    logic [4:0][4:0]        sa_grant;
    logic [4:0][FLIT_W-1:0] flit_out;
    logic [4:0]             valid_flit_out;
    logic                   protocol_err;

    modport master (
        output sa_request, outport_req, flit_in, valid_flit_in,
               valid_downstream_ports,
        input  sa_grant, flit_out, valid_flit_out, protocol_err
    );

    modport slave (
        input  sa_request, outport_req, flit_in, valid_flit_in,
               valid_downstream_ports,
        output sa_grant, flit_out, valid_flit_out, protocol_err
    );

endinterface

// File: rtl/switch_allocator_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter_5
// Five-request round-robin arbiter with an internal wrap pointer.
//   clk, rst     clock and synchronous active-high reset (pointer -> 0)
//   i_req        request vector, bit i = input i
//   i_grant_en   update strobe: advance the pointer past the current winner
//   o_valid      some request is present
//   o_idx        winning input index (0-4)
// The winner is the first requester found scanning r_ptr, r_ptr+1, ... mod 5.
// ----------------------------------------------------------------------------
module rr_arbiter_5
    import router_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] i_req,
    input  logic       i_grant_en,
    output logic       o_valid,
    output logic [2:0] o_idx
);

    logic [2:0] r_ptr;
    logic [3:0] w_cand;

    // Scan from the farthest candidate back to the pointer so that the
    // nearest requester in round-robin order is the last one assigned.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int k = NPORT - 1; k >= 0; k--) begin
            w_cand = {1'b0, r_ptr} + 4'(k);
            if (w_cand >= 4'(NPORT)) begin
                w_cand = w_cand - 4'(NPORT);
            end
            if (i_req[w_cand[2:0]]) begin
                o_valid = 1'b1;
                o_idx   = w_cand[2:0];
            end
        end
    end

    // Pointer moves just past the winner on a granted cycle, otherwise holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_grant_en && o_valid) begin
            r_ptr <= (o_idx == 3'(NPORT - 1)) ? 3'd0 : o_idx + 3'd1;
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// ----------------------------------------------------------------------------
// switch_allocator
// Switch allocation plus 5x5 crossbar of the wormhole router.
//   clk   clock
//   rst   synchronous active-high reset
//   bus   switch_allocator_if.slave: requests/flits from the five input
//         ports, readiness of the five output links, registered grants back
//         to the inputs and registered flits toward the outputs.
// Cycle N requests are arbitrated per output; the grant is registered and
// shown to the inputs in N+1; the winner's flit lands in the output slot in
// N+2.
// ----------------------------------------------------------------------------
module switch_allocator
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    switch_allocator_if.slave bus
);

    grant_t [NPORT-1:0]             r_gntQ;
    logic   [NPORT-1:0][FLIT_W-1:0] r_flitOut;
    logic   [NPORT-1:0]             r_validOut;
    logic                           r_protoErr;

    logic   [NPORT-1:0]             w_granted;
    logic   [NPORT-1:0][NPORT-1:0]  w_eligible;
    logic   [NPORT-1:0]             w_arbValid;
    logic   [NPORT-1:0][2:0]        w_arbIdx;
    logic   [NPORT-1:0]             w_anyReq;

    // Which inputs hold a grant this cycle; this is both the grant shown to
    // the inputs and the back-to-back mask for the arbitration running now.
    always_comb begin
        w_granted = '0;
        for (int o = 0; o < NPORT; o++) begin
            if (r_gntQ[o].valid) begin
                w_granted[r_gntQ[o].idx] = 1'b1;
            end
        end
    end

    // The grant seen by input i is its own direction code, purely from flops.
    always_comb begin
        bus.sa_grant = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (w_granted[i]) begin
                bus.sa_grant[i] = dirCode(3'(i));
            end
        end
    end

    // Request filtering: malformed (not one-hot) requests, blocked outputs
    // and inputs that were just granted never reach an arbiter.
    always_comb begin
        w_eligible = '0;
        w_anyReq   = '0;
        for (int o = 0; o < NPORT; o++) begin
            for (int i = 0; i < NPORT; i++) begin
                w_eligible[o][i] = bus.sa_request[i]
                                 & bus.outport_req[i][o]
                                 & isOneHot5(bus.outport_req[i])
                                 & bus.valid_downstream_ports[o]
                                 & ~w_granted[i];
            end
            w_anyReq[o] = |w_eligible[o];
        end
    end

    for (genvar o = 0; o < NPORT; o++) begin : g_arb
        rr_arbiter_5 u_arb (
            .clk        (clk),
            .rst        (rst),
            .i_req      (w_eligible[o]),
            .i_grant_en (w_anyReq[o]),
            .o_valid    (w_arbValid[o]),
            .o_idx      (w_arbIdx[o])
        );
    end

    // Grant register is reloaded every cycle, so each grant lasts one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gntQ <= '0;
        end else begin
            for (int o = 0; o < NPORT; o++) begin
                r_gntQ[o] <= '{valid: w_arbValid[o], idx: w_arbIdx[o]};
            end
        end
    end

    // Crossbar traversal: a granted output copies its winner's flit; a winner
    // that fails to present a valid flit raises the sticky protocol error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flitOut  <= '0;
            r_validOut <= '0;
            r_protoErr <= 1'b0;
        end else begin
            for (int o = 0; o < NPORT; o++) begin
                if (r_gntQ[o].valid) begin
                    r_flitOut[o]  <= bus.flit_in[r_gntQ[o].idx];
                    r_validOut[o] <= bus.valid_flit_in[r_gntQ[o].idx];
                    if (!bus.valid_flit_in[r_gntQ[o].idx]) begin
                        r_protoErr <= 1'b1;
                    end
                end else begin
                    r_validOut[o] <= 1'b0;
                end
            end
        end
    end

    assign bus.flit_out       = r_flitOut;
    assign bus.valid_flit_out = r_validOut;
    assign bus.protocol_err   = r_protoErr;

endmodule

// File: tb/tb_switch_allocator.sv
// ----------------------------------------------------------------------------
// tb_switch_allocator
// Bench for switch_allocator. A cycle-level reference model (round-robin
// pointers as integers, grants as winner indices) predicts the registered
// outputs for every driven cycle and queues them; a monitor compares the DUT
// against the queue just after each rising edge. Directed scenarios add
// fixed expectations for the key behaviours, then randomized traffic runs.
// ----------------------------------------------------------------------------
module tb_switch_allocator;
    import router_pkg::*;

    typedef struct packed {
        logic [4:0][4:0]  grant;
        logic [4:0]       vfo;
        logic [4:0][63:0] fo;
        logic             err;
    } expRec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    switch_allocator_if bus ();

    switch_allocator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    expRec_t expQ[$];

    int          mRr  [5];
    int          mGnt [5];
    logic [4:0]  mVfo;
    logic [63:0] mFo  [5];
    logic        mErr;

    logic [63:0] stimFlit [5];
    logic [4:0]  stimDrop;

    // Compare one observed value against its required value.
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    function automatic bit modelGranted(input int i);
        for (int o = 0; o < 5; o++) begin
            if (mGnt[o] == i) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic randomizeFlits();
        for (int i = 0; i < 5; i++) begin
            stimFlit[i] = {$urandom, $urandom};
        end
    endtask

    // Drive one cycle of inputs (caller is at a falling edge), advance the
    // reference model across the next rising edge and queue its prediction.
    task automatic applyStimulus(input logic iRst, input logic [4:0] req,
                                 input logic [4:0][4:0] oreq, input logic [4:0] ds);
        logic [4:0] vfi;
        int         nGnt [5];
        int         win, cand;
        expRec_t    e;
        for (int i = 0; i < 5; i++) begin
            if (modelGranted(i)) vfi[i] = ~stimDrop[i];
            else                 vfi[i] = 1'($urandom_range(0, 1));
        end
        rst                        = iRst;
        bus.sa_request             = req;
        bus.outport_req            = oreq;
        bus.valid_downstream_ports = ds;
        bus.valid_flit_in          = vfi;
        for (int i = 0; i < 5; i++) bus.flit_in[i] = stimFlit[i];

        if (iRst) begin
            for (int o = 0; o < 5; o++) begin
                nGnt[o] = -1;
                mRr[o]  = 0;
                mFo[o]  = '0;
            end
            mVfo = '0;
            mErr = 1'b0;
        end else begin
            for (int o = 0; o < 5; o++) begin
                win = -1;
                for (int k = 0; k < 5; k++) begin
                    cand = (mRr[o] + k) % 5;
                    if (win < 0 && req[cand] && $countones(oreq[cand]) == 1 &&
                        oreq[cand][o] && ds[o] && !modelGranted(cand)) begin
                        win = cand;
                    end
                end
                nGnt[o] = win;
            end
            for (int o = 0; o < 5; o++) begin
                if (mGnt[o] >= 0) begin
                    mFo[o]  = stimFlit[mGnt[o]];
                    mVfo[o] = vfi[mGnt[o]];
                    if (!vfi[mGnt[o]]) mErr = 1'b1;
                end else begin
                    mVfo[o] = 1'b0;
                end
                if (nGnt[o] >= 0) mRr[o] = (nGnt[o] + 1) % 5;
            end
        end
        for (int o = 0; o < 5; o++) mGnt[o] = nGnt[o];

        e = '0;
        for (int o = 0; o < 5; o++) begin
            if (mGnt[o] >= 0) e.grant[mGnt[o]] = 5'b00001 << mGnt[o];
            e.fo[o] = mFo[o];
        end
        e.vfo = mVfo;
        e.err = mErr;
        expQ.push_back(e);
        stimDrop = '0;
    endtask

    // Monitor: every cycle that has a prediction, compare the full DUT state.
    initial begin
        expRec_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("sb_sa_grant", 64'(bus.sa_grant), 64'(e.grant));
                checkOutput("sb_valid_flit_out", 64'(bus.valid_flit_out), 64'(e.vfo));
                checkOutput("sb_protocol_err", 64'(bus.protocol_err), 64'(e.err));
                for (int o = 0; o < 5; o++) begin
                    checkOutput($sformatf("sb_flit_out%0d", o), bus.flit_out[o], e.fo[o]);
                end
            end
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        logic [4:0][4:0] oreq;
        logic [4:0][4:0] ev;
        logic [4:0]      ds;
        int              order [4];

        bus.sa_request             = '0;
        bus.outport_req            = '0;
        bus.flit_in                = '0;
        bus.valid_flit_in          = '0;
        bus.valid_downstream_ports = '0;
        stimDrop                   = '0;
        for (int o = 0; o < 5; o++) begin
            mGnt[o] = -1;
            mRr[o]  = 0;
            mFo[o]  = '0;
        end
        mVfo = '0;
        mErr = 1'b0;
        randomizeFlits();

        // Reset state.
        @(negedge clk); applyStimulus(1'b1, '0, '0, 5'h1f);
        @(negedge clk); applyStimulus(1'b1, '0, '0, 5'h1f);
        @(negedge clk);
        checkOutput("reset_sa_grant", 64'(bus.sa_grant), 64'd0);
        checkOutput("reset_valid_flit_out", 64'(bus.valid_flit_out), 64'd0);
        checkOutput("reset_protocol_err", 64'(bus.protocol_err), 64'd0);
        checkOutput("reset_flit_out1", bus.flit_out[1], 64'd0);

        // Single request W -> E, flit A5 driven in the grant cycle.
        oreq = '0; oreq[3] = DIR_E;
        applyStimulus(1'b0, DIR_W, oreq, 5'h1f);
        @(negedge clk);
        checkOutput("single_grant_n1", 64'(bus.sa_grant[3]), 64'(DIR_W));
        stimFlit[3] = 64'hA5;
        applyStimulus(1'b0, '0, '0, 5'h1f);
        @(negedge clk);
        checkOutput("single_grant_n2", 64'(bus.sa_grant[3]), 64'd0);
        checkOutput("single_flit_out1", bus.flit_out[1], 64'hA5);
        checkOutput("single_valid_out1", 64'(bus.valid_flit_out[1]), 64'd1);

        // Conflict N, S, L -> E from a reset pointer: N, S, L, then N again.
        applyStimulus(1'b1, '0, '0, 5'h1f);
        order[0] = 0; order[1] = 2; order[2] = 4; order[3] = 0;
        oreq = '0; oreq[0] = DIR_E; oreq[2] = DIR_E; oreq[4] = DIR_E;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c > 0) begin
                ev = '0; ev[order[c-1]] = 5'b00001 << order[c-1];
                checkOutput($sformatf("conflict_grant%0d", c), 64'(bus.sa_grant), 64'(ev));
            end
            randomizeFlits();
            if (c < 4) applyStimulus(1'b0, DIR_N | DIR_S | DIR_L, oreq, 5'h1f);
            else       applyStimulus(1'b0, '0, '0, 5'h1f);
        end

        // Parallel traffic: all five inputs to distinct outputs at once.
        @(negedge clk);
        oreq = '0;
        oreq[0] = DIR_S; oreq[2] = DIR_N; oreq[1] = DIR_W; oreq[3] = DIR_E; oreq[4] = DIR_L;
        randomizeFlits();
        applyStimulus(1'b0, 5'h1f, oreq, 5'h1f);
        @(negedge clk);
        ev = '0;
        for (int i = 0; i < 5; i++) ev[i] = 5'b00001 << i;
        checkOutput("parallel_grant", 64'(bus.sa_grant), 64'(ev));
        applyStimulus(1'b0, '0, '0, 5'h1f);
        @(negedge clk);
        checkOutput("parallel_valid_out", 64'(bus.valid_flit_out), 64'h1f);

        // Blocked output E for three cycles, then ready.
        oreq = '0; oreq[3] = DIR_E;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) begin
                @(negedge clk);
                checkOutput($sformatf("blocked_grant%0d", c), 64'(bus.sa_grant[3]), 64'd0);
            end
            ds = (c < 3) ? 5'h1d : 5'h1f;
            applyStimulus(1'b0, DIR_W, oreq, ds);
        end
        @(negedge clk);
        checkOutput("unblocked_grant", 64'(bus.sa_grant[3]), 64'(DIR_W));
        applyStimulus(1'b0, '0, '0, 5'h1f);

        // Protocol error: N granted on E but withholds its flit.
        @(negedge clk); applyStimulus(1'b1, '0, '0, 5'h1f);
        oreq = '0; oreq[0] = DIR_E;
        @(negedge clk); applyStimulus(1'b0, DIR_N, oreq, 5'h1f);
        @(negedge clk);
        stimDrop[0] = 1'b1;
        applyStimulus(1'b0, '0, '0, 5'h1f);
        @(negedge clk);
        checkOutput("proto_err_set", 64'(bus.protocol_err), 64'd1);
        checkOutput("proto_valid_out", 64'(bus.valid_flit_out), 64'd0);
        applyStimulus(1'b0, '0, '0, 5'h1f);

        // Reset during an outstanding grant, then pointer restarts at N.
        oreq = '0; oreq[2] = DIR_E;
        @(negedge clk); applyStimulus(1'b0, DIR_S, oreq, 5'h1f);
        @(negedge clk); applyStimulus(1'b1, '0, '0, 5'h1f);
        @(negedge clk);
        checkOutput("rst_mid_sa_grant", 64'(bus.sa_grant), 64'd0);
        checkOutput("rst_mid_valid_out", 64'(bus.valid_flit_out), 64'd0);
        checkOutput("rst_mid_protocol_err", 64'(bus.protocol_err), 64'd0);
        checkOutput("rst_mid_flit_out1", bus.flit_out[1], 64'd0);
        oreq = '0; oreq[0] = DIR_E; oreq[2] = DIR_E; oreq[4] = DIR_E;
        applyStimulus(1'b0, DIR_N | DIR_S | DIR_L, oreq, 5'h1f);
        @(negedge clk);
        ev = '0; ev[0] = DIR_N;
        checkOutput("rst_rr_restart", 64'(bus.sa_grant), 64'(ev));
        applyStimulus(1'b0, '0, '0, 5'h1f);

        // Randomized traffic with occasional resets, blocks and bad requests.
        for (int n = 0; n < 600; n++) begin
            logic [4:0] req;
            @(negedge clk);
            randomizeFlits();
            req = 5'($urandom);
            for (int i = 0; i < 5; i++) begin
                if ($urandom_range(0, 7) == 0) oreq[i] = 5'($urandom);
                else                           oreq[i] = 5'b00001 << $urandom_range(0, 4);
                stimDrop[i] = ($urandom_range(0, 15) == 0);
            end
            ds = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'h1f;
            applyStimulus(($urandom_range(0, 63) == 0), req, oreq, ds);
        end
        @(negedge clk); applyStimulus(1'b0, '0, '0, 5'h1f);

        for (int k = 0; k < 10 && expQ.size() != 0; k++) @(posedge clk);
        @(posedge clk);
        #2;
        if (expQ.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_timeout actual=%0d required=0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
